// File: rtl/instr_feeder_if.sv
// Program-load / replay bus between a stimulus master and instr_feeder.
interface instr_feeder_if #(
    parameter int DEPTH = 16
) ();
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     start;
    logic                     clr;
    logic [7:0]               instr_out;
    logic                     cpu_reset;
    logic                     busy;
    logic                     done;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output wr_en, wr_data, start, clr,
        input  instr_out, cpu_reset, busy, done, full, count
    );

    modport slave (
        input  wr_en, wr_data, start, clr,
        output instr_out, cpu_reset, busy, done, full, count
    );
endinterface

// File: rtl/instr_feeder.sv
// Stores a short program of instruction bytes and replays it onto the cpu input bus,
// holding each byte one or two cycles according to its opcode class.
module instr_feeder #(
    parameter int          DEPTH      = 16,
    parameter logic [15:0] MULTI_MASK = 16'h15C0
) (
    input logic           clk,
    input logic           reset,
    instr_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [7:0]       mem [DEPTH];
    logic [CNT_W-1:0] count, count_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n, rd_ptr_inc;
    logic [7:0]       instr, instr_n;
    logic             cpu_rst, cpu_rst_n;
    logic             done_q, done_n;
    logic             held, held_n;
    logic             mem_we;
    logic             full;
    logic             is_last;

    assign full       = (count == CNT_W'(DEPTH));
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign is_last    = (CNT_W'(rd_ptr) + CNT_W'(1)) >= count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rd_ptr  <= '0;
            instr   <= '0;
            cpu_rst <= 1'b1;
            done_q  <= 1'b0;
            held    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            rd_ptr  <= rd_ptr_n;
            instr   <= instr_n;
            cpu_rst <= cpu_rst_n;
            done_q  <= done_n;
            held    <= held_n;
        end
    end

    // Program storage is deliberately left unreset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count[PTR_W-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        rd_ptr_n  = rd_ptr;
        instr_n   = instr;
        cpu_rst_n = cpu_rst;
        done_n    = done_q;
        held_n    = held;
        mem_we    = 1'b0;

        if (bus.clr) begin
            state_n   = IDLE;
            count_n   = '0;
            rd_ptr_n  = '0;
            instr_n   = '0;
            cpu_rst_n = 1'b1;
            done_n    = 1'b0;
            held_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && count != '0) begin
                        state_n   = RUN;
                        instr_n   = mem[0];
                        rd_ptr_n  = '0;
                        cpu_rst_n = 1'b0;
                        held_n    = 1'b0;
                    end else if (bus.wr_en && !full && !bus.start) begin
                        mem_we  = !reset;
                        count_n = count + CNT_W'(1);
                    end
                end
                RUN: begin
                    // A two-cycle byte spends its first cycle setting held.
                    if (MULTI_MASK[instr[7:4]] && !held) begin
                        held_n = 1'b1;
                    end else if (!is_last) begin
                        rd_ptr_n = rd_ptr_inc;
                        instr_n  = mem[rd_ptr_inc];
                        held_n   = 1'b0;
                    end else begin
                        state_n = DONE;
                        instr_n = '0;
                        done_n  = 1'b1;
                        held_n  = 1'b0;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_n  = RUN;
                        instr_n  = mem[0];
                        rd_ptr_n = '0;
                        done_n   = 1'b0;
                        held_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.instr_out = instr;
    assign bus.cpu_reset = cpu_rst;
    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.full      = full;
    assign bus.count     = count;
endmodule
